axi_wdata_router: RTL and testbench
===================================

AXI_WDATA_ROUTER -- requirements
Module: axi_wdata_router

Interface
REQ-001 SHALL have parameters, one per line:
- N_INIT_PORT, default 4, number of master (init) ports, >=1.
- FIFO_DEPTH, default 8, routing-FIFO entries, power of 2, >=2.
- BYPASS, default 1, when 1 an entry pushed into an empty FIFO routes W beats in the same cycle.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- wvalid_i  in  1  slave-side W valid.
- wlast_i  in  1  slave-side W last beat.
- wready_o  out  1  slave-side W ready.
- wvalid_o  out  N_INIT_PORT  per-master W valid.
- wready_i  in  N_INIT_PORT  per-master W ready.
- push_dest_i  in  1  AW decoder pushes a routing entry.
- dest_i  in  N_INIT_PORT  one-hot target of the pushed entry.
- dest_error_i  in  1  pushed entry is a decode-error burst.
- grant_dest_o  out  1  routing FIFO can accept an entry.
- wdata_error_completed_o  out  1  last beat of an error burst absorbed.
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  stored entries.
- wdata_idle_o  out  1  no entry stored.

Function
REQ-003 SHALL store entries {dest, err} in an internal circular FIFO of FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
REQ-004 SHALL drive grant_dest_o = (fifo_count_o < FIFO_DEPTH); push accepted when push_dest_i & grant_dest_o; no push-through when full, even with a same-cycle pop.
REQ-005 SHALL store an entry with dest_i == 0 as an error entry regardless of dest_error_i.
REQ-006 SHALL define head valid = (count > 0) | (BYPASS & accepted push & count == 0); head = stored head entry if count > 0, else the entry being pushed.
REQ-007 Normal head (err=0): wvalid_o = dest & {N{wvalid_i}}; wready_o = |(wready_i & dest); wdata_error_completed_o = 0.
REQ-008 Error head (err=1): wvalid_o = 0; wready_o = 1; wdata_error_completed_o = wvalid_i & wlast_i.
REQ-009 No valid head: wvalid_o = 0, wready_o = 0, wdata_error_completed_o = 0; W beats stall.
REQ-010 wvalid_o SHALL NOT depend combinationally on wready_i; wready_o MAY depend combinationally on wready_i.
REQ-011 Pop = head valid & wvalid_i & wready_o & wlast_i; a pop advances to the next entry on the following cycle; non-last beats do not pop.
REQ-012 Bypass pop (count == 0, BYPASS=1, push and pop same cycle) SHALL leave count and pointers unchanged.
REQ-013 Count: push only -> +1; pop only -> -1; push & pop with count > 0 -> unchanged, both pointers advance.
REQ-014 SHALL assert wdata_idle_o = (fifo_count_o == 0).
REQ-015 BYPASS=0: a pushed entry becomes head one cycle after the push at the earliest.
REQ-016 Beats of consecutive bursts SHALL be routed strictly in push order, with no bubble between the last beat of one burst and the first beat of the next when the next entry is stored.

Reset
REQ-017 While rst_n = 0, asynchronously: count = 0, pointers = 0, grant_dest_o = 1, wready_o = 0, wvalid_o = 0, wdata_error_completed_o = 0, fifo_count_o = 0, wdata_idle_o = 1.
REQ-018 Reset mid-burst SHALL discard all stored entries; FIFO storage contents need not be reset.

Verification (N_INIT_PORT=4, FIFO_DEPTH=4)
REQ-019 BYPASS=1, empty: push dest=4'b0100 with wvalid_i=1, wlast_i=1, wready_i=4'b0100 in the same cycle -> wvalid_o=4'b0100, wready_o=1, fifo_count_o stays 0.
REQ-020 Push 4 entries, no W traffic -> grant_dest_o=0, fifo_count_o=4; 5th push ignored; one last-beat pop with a same-cycle push -> count 3, then 4 on the next push.
REQ-021 Entries 4'b0001 (3 beats) then 4'b1000 (1 beat), wready_i=4'b1111 -> beats 1-3 on port 0, beat 4 on port 3 with no idle cycle; count 2->1->0.
REQ-022 Error entry (dest_error_i=1), 2 beats, wready_i=0 -> wready_o=1, wvalid_o=0, wdata_error_completed_o=1 only on the wlast_i beat.
REQ-023 Push dest_i=0, dest_error_i=0 -> treated as error: beats absorbed, completion pulse on last beat.
REQ-024 rst_n low mid-burst with count=3 -> all outputs at REQ-017 values immediately; after release, the first W beat stalls until a new push.

Source files
------------

// File: rtl/axi_wdata_router.sv
// W-channel router: AW-side decoder pushes one-hot destinations into a routing FIFO,
// and W beats follow the head entry until its last beat; error entries absorb beats.
module axi_wdata_router #(
  parameter int N_INIT_PORT = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wvalid_i,
  input  logic                                 wlast_i,
  output logic                                 wready_o,
  output logic [N_INIT_PORT-1:0]               wvalid_o,
  input  logic [N_INIT_PORT-1:0]               wready_i,
  input  logic                                 push_dest_i,
  input  logic [N_INIT_PORT-1:0]               dest_i,
  input  logic                                 dest_error_i,
  output logic                                 grant_dest_o,
  output logic                                 wdata_error_completed_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o,
  output logic                                 wdata_idle_o
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [N_INIT_PORT-1:0] dest_mem [FIFO_DEPTH];
  logic                   err_mem  [FIFO_DEPTH];

  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic                   push_acc, push_err, store_empty;
  logic                   head_valid, head_err;
  logic [N_INIT_PORT-1:0] head_dest;
  logic                   pop, bypass_pop, do_push, do_pop;

  assign store_empty  = (count == '0);
  assign grant_dest_o = (count < FULL);
  assign fifo_count_o = count;
  assign wdata_idle_o = store_empty;

  // push is gated by rst_n so a bypass head cannot appear while reset is held
  assign push_acc = push_dest_i & grant_dest_o & rst_n;
  assign push_err = dest_error_i | (dest_i == '0);

  assign head_valid = !store_empty || (BYPASS && push_acc);
  assign head_dest  = store_empty ? dest_i   : dest_mem[rd_ptr];
  assign head_err   = store_empty ? push_err : err_mem[rd_ptr];

  always_comb begin
    wvalid_o                = '0;
    wready_o                = 1'b0;
    wdata_error_completed_o = 1'b0;
    if (head_valid) begin
      if (head_err) begin
        wready_o                = 1'b1;
        wdata_error_completed_o = wvalid_i & wlast_i;
      end else begin
        wvalid_o = head_dest & {N_INIT_PORT{wvalid_i}};
        wready_o = |(wready_i & head_dest);
      end
    end
  end

  assign pop        = head_valid & wvalid_i & wready_o & wlast_i;
  assign bypass_pop = pop & store_empty;
  assign do_push    = push_acc & ~bypass_pop;
  assign do_pop     = pop & ~store_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage is not reset; only pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      dest_mem[wr_ptr] <= dest_i;
      err_mem[wr_ptr]  <= push_err;
    end
  end

endmodule

// File: tb/tb_axi_wdata_router.sv
// Directed bench for axi_wdata_router (4 ports, depth 4, bypass on); accepted W beats
// are checked against a queue of expected {wvalid_o, completion} records.
module tb_axi_wdata_router;

  logic       clk, rst_n;
  logic       wvalid_i, wlast_i, wready_o;
  logic [3:0] wvalid_o, wready_i, dest_i;
  logic       push_dest_i, dest_error_i, grant_dest_o, wdata_error_completed_o;
  logic [2:0] fifo_count_o;
  logic       wdata_idle_o;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q [$];

  axi_wdata_router #(.N_INIT_PORT(4), .FIFO_DEPTH(4), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wvalid_i(wvalid_i), .wlast_i(wlast_i), .wready_o(wready_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .push_dest_i(push_dest_i), .dest_i(dest_i), .dest_error_i(dest_error_i),
    .grant_dest_o(grant_dest_o), .wdata_error_completed_o(wdata_error_completed_o),
    .fifo_count_o(fifo_count_o), .wdata_idle_o(wdata_idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [3:0] wv, input logic done);
    exp_q.push_back({wv, done});
  endtask

  task automatic cyc(input logic push, input logic [3:0] dest, input logic derr,
                     input logic wv, input logic wl, input logic [3:0] wr);
    push_dest_i = push; dest_i = dest; dest_error_i = derr;
    wvalid_i = wv; wlast_i = wl; wready_i = wr;
    @(posedge clk); #1;
    push_dest_i = 1'b0; dest_error_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
  endtask

  // monitor: every accepted W beat must match the oldest expected record
  always @(negedge clk) begin
    if (rst_n && wvalid_i && wready_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL w_beat: unexpected beat wvalid_o=%b done=%b", wvalid_o, wdata_error_completed_o);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({wvalid_o, wdata_error_completed_o} !== e) begin
          errors++;
          $display("FAIL w_beat: got wvalid_o=%b done=%b expected wvalid_o=%b done=%b",
                   wvalid_o, wdata_error_completed_o, e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    push_dest_i = 1'b1; dest_i = 4'b0100; dest_error_i = 1'b0;
    wvalid_i = 1'b1; wlast_i = 1'b1; wready_i = 4'b1111;
    #12;
    chk("rst_wready", wready_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_done", wdata_error_completed_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_idle", wdata_idle_o, 1);
    chk("rst_grant", grant_dest_o, 1);
    push_dest_i = 1'b0; wvalid_i = 1'b0; wlast_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // bypass: push and single-beat burst in one cycle
    exp_beat(4'b0100, 1'b0);
    cyc(1, 4'b0100, 0, 1, 1, 4'b0100);
    chk("bypass_count", fifo_count_o, 0);

    // no head: beats stall
    wvalid_i = 1; wlast_i = 1; wready_i = 4'b1111; #2;
    chk("empty_wready", wready_o, 0);
    chk("empty_wvalid", wvalid_o, 0);
    wvalid_i = 0; wlast_i = 0;
    @(posedge clk); #1;

    // ready of a non-target port does not complete a beat
    cyc(1, 4'b0100, 0, 0, 0, 4'b0000);
    chk("one_count", fifo_count_o, 1);
    wvalid_i = 1; wlast_i = 1; wready_i = 4'b1011; #2;
    chk("mask_wready", wready_o, 0);
    chk("mask_wvalid", wvalid_o, 4'b0100);
    exp_beat(4'b0100, 1'b0);
    cyc(0, 4'b0000, 0, 1, 1, 4'b1111);
    chk("mask_count", fifo_count_o, 0);

    // fill to full, ignored push, pop with push while full
    cyc(1, 4'b0001, 0, 0, 0, 4'b0000);
    cyc(1, 4'b0010, 0, 0, 0, 4'b0000);
    cyc(1, 4'b0100, 0, 0, 0, 4'b0000);
    cyc(1, 4'b1000, 0, 0, 0, 4'b0000);
    chk("full_count", fifo_count_o, 4);
    chk("full_grant", grant_dest_o, 0);
    cyc(1, 4'b0001, 0, 0, 0, 4'b0000);
    chk("full_push_ignored", fifo_count_o, 4);
    exp_beat(4'b0001, 1'b0);
    cyc(1, 4'b0010, 0, 1, 1, 4'b0001);
    chk("full_pop_push", fifo_count_o, 3);
    cyc(1, 4'b0010, 0, 0, 0, 4'b0000);
    chk("refill_count", fifo_count_o, 4);
    exp_beat(4'b0010, 1'b0); cyc(0, 4'b0000, 0, 1, 1, 4'b1111);
    chk("drain_3", fifo_count_o, 3);
    exp_beat(4'b0100, 1'b0); cyc(0, 4'b0000, 0, 1, 1, 4'b1111);
    exp_beat(4'b1000, 1'b0); cyc(0, 4'b0000, 0, 1, 1, 4'b1111);
    exp_beat(4'b0010, 1'b0); cyc(0, 4'b0000, 0, 1, 1, 4'b1111);
    chk("drain_0", fifo_count_o, 0);
    chk("drain_q", exp_q.size(), 0);

    // back-to-back bursts, no bubble
    cyc(1, 4'b0001, 0, 0, 0, 4'b0000);
    cyc(1, 4'b1000, 0, 0, 0, 4'b0000);
    exp_beat(4'b0001, 1'b0); cyc(0, 4'b0000, 0, 1, 0, 4'b1111);
    exp_beat(4'b0001, 1'b0); cyc(0, 4'b0000, 0, 1, 0, 4'b1111);
    chk("b2b_mid_count", fifo_count_o, 2);
    exp_beat(4'b0001, 1'b0); cyc(0, 4'b0000, 0, 1, 1, 4'b1111);
    chk("b2b_count_1", fifo_count_o, 1);
    exp_beat(4'b1000, 1'b0); cyc(0, 4'b0000, 0, 1, 1, 4'b1111);
    chk("b2b_count_0", fifo_count_o, 0);
    chk("b2b_q", exp_q.size(), 0);

    // explicit error entry, 2 beats, no downstream ready
    cyc(1, 4'b0010, 1, 0, 0, 4'b0000);
    exp_beat(4'b0000, 1'b0); cyc(0, 4'b0000, 0, 1, 0, 4'b0000);
    exp_beat(4'b0000, 1'b1); cyc(0, 4'b0000, 0, 1, 1, 4'b0000);
    chk("err_count", fifo_count_o, 0);

    // zero destination is an error entry, stored and bypassed
    cyc(1, 4'b0000, 0, 0, 0, 4'b0000);
    exp_beat(4'b0000, 1'b0); cyc(0, 4'b0000, 0, 1, 0, 4'b0000);
    exp_beat(4'b0000, 1'b1); cyc(0, 4'b0000, 0, 1, 1, 4'b0000);
    exp_beat(4'b0000, 1'b1); cyc(1, 4'b0000, 0, 1, 1, 4'b0000);
    chk("zero_dest_count", fifo_count_o, 0);
    chk("err_q", exp_q.size(), 0);

    // reset mid-burst with three entries stored
    cyc(1, 4'b0001, 0, 0, 0, 4'b0000);
    cyc(1, 4'b0010, 0, 0, 0, 4'b0000);
    cyc(1, 4'b0100, 0, 0, 0, 4'b0000);
    exp_beat(4'b0001, 1'b0); cyc(0, 4'b0000, 0, 1, 0, 4'b1111);
    chk("pre_rst_count", fifo_count_o, 3);
    wvalid_i = 1; wlast_i = 0; wready_i = 4'b1111; #1;
    rst_n = 1'b0; #1;
    chk("mid_rst_wready", wready_o, 0);
    chk("mid_rst_wvalid", wvalid_o, 0);
    chk("mid_rst_count", fifo_count_o, 0);
    chk("mid_rst_idle", wdata_idle_o, 1);
    chk("mid_rst_grant", grant_dest_o, 1);
    wvalid_i = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wvalid_i = 1; wlast_i = 1; wready_i = 4'b1111; #2;
    chk("post_rst_stall", wready_o, 0);
    chk("post_rst_count", fifo_count_o, 0);
    exp_beat(4'b1000, 1'b0);
    cyc(1, 4'b1000, 0, 1, 1, 4'b1111);
    chk("post_rst_bypass", fifo_count_o, 0);
    chk("final_q", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
